// File: rtl/mel_pkg.sv
// rtl/mel_pkg.sv - shared log-mel framing constants, FSM state type and width helper
package mel_pkg;

    localparam int N_BINS_DEF   = 513;
    localparam int N_FRAMES_DEF = 89;
    localparam int D_BW_DEF     = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP,
        ST_DONE
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spec_frame_tx_if.sv
// rtl/spec_frame_tx_if.sv - upstream sample handshake plus tagged spectral output stream
interface spec_frame_tx_if
    import mel_pkg::*;
#(
    parameter int D_BW  = D_BW_DEF,
    parameter int IDX_W = 10,
    parameter int NUM_W = 7
);
    logic signed [D_BW-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic signed [D_BW-1:0] data_o;
    logic                   do_en;
    logic [IDX_W-1:0]       group_idx;
    logic [NUM_W-1:0]       group_num;
    logic                   is_first;
    logic                   is_last;

    modport master (
        output s_data, s_valid,
        input  s_ready, data_o, do_en, group_idx, group_num, is_first, is_last
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, data_o, do_en, group_idx, group_num, is_first, is_last
    );
endinterface

// File: rtl/spec_frame_tx_frame_counter.sv
// rtl/spec_frame_tx_frame_counter.sv - nested bin/frame counter with wrap and last flags
module frame_counter
    import mel_pkg::*;
#(
    parameter int N_BINS   = N_BINS_DEF,
    parameter int N_FRAMES = N_FRAMES_DEF,
    parameter int IDX_W    = cnt_w(N_BINS),
    parameter int NUM_W    = cnt_w(N_FRAMES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] bin,
    output logic [NUM_W-1:0] frame,
    output logic             last_bin,
    output logic             last_frame,
    output logic             wrap
);
    assign last_bin   = (bin == IDX_W'(N_BINS - 1));
    assign last_frame = (frame == NUM_W'(N_FRAMES - 1));
    assign wrap       = inc && last_bin;

    // The frame count saturates on the final wrap so it never leaves its range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin   <= '0;
            frame <= '0;
        end else if (clear) begin
            bin   <= '0;
            frame <= '0;
        end else if (inc) begin
            if (last_bin) begin
                bin <= '0;
                if (!last_frame)
                    frame <= frame + 1'b1;
            end else begin
                bin <= bin + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spec_frame_tx.sv
// rtl/spec_frame_tx.sv - framing transmitter emitting bin/frame tagged samples for the log stage
module spec_frame_tx
    import mel_pkg::*;
#(
    parameter int D_BW     = D_BW_DEF,
    parameter int N_BINS   = N_BINS_DEF,
    parameter int N_FRAMES = N_FRAMES_DEF,
    parameter int GAP      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    spec_frame_tx_if.slave    bus,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = cnt_w(N_BINS);
    localparam int NUM_W = cnt_w(N_FRAMES);
    localparam int GAP_W = cnt_w(GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state, state_nxt;
    logic             ready, accept, clear;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] bin;
    logic [NUM_W-1:0] frame;
    logic             last_bin, last_frame, wrap;

    frame_counter #(
        .N_BINS   (N_BINS),
        .N_FRAMES (N_FRAMES),
        .IDX_W    (IDX_W),
        .NUM_W    (NUM_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .inc        (accept),
        .bin        (bin),
        .frame      (frame),
        .last_bin   (last_bin),
        .last_frame (last_frame),
        .wrap       (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        clear     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_STREAM;
                    clear     = 1'b1;
                end
            end
            ST_STREAM: begin
                ready = 1'b1;
                if (bus.s_valid && last_bin) begin
                    if (last_frame)
                        state_nxt = ST_DONE;
                    else
                        state_nxt = (GAP > 0) ? ST_GAP : ST_STREAM;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0)
                    state_nxt = ST_STREAM;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept      = ready && bus.s_valid;
    assign bus.s_ready = ready;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            gap_cnt <= '0;
        else if (wrap && !last_frame)
            gap_cnt <= GAP_LOAD;
        else if (state == ST_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end

    // Tags come from the counter values before this beat's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_o    <= '0;
            bus.do_en     <= 1'b0;
            bus.group_idx <= '0;
            bus.group_num <= '0;
            bus.is_first  <= 1'b0;
            bus.is_last   <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.do_en    <= accept;
            bus.is_first <= accept && (bin == '0);
            bus.is_last  <= accept && last_bin;
            done         <= (state == ST_DONE);
            if (accept) begin
                bus.data_o    <= bus.s_data;
                bus.group_idx <= bin;
                bus.group_num <= frame;
            end
        end
    end
endmodule

// File: tb/tb_spec_frame_tx.sv
// tb/tb_spec_frame_tx.sv - directed self-checking bench for spec_frame_tx
module tb_spec_frame_tx;
    import mel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

    spec_frame_tx_if #(.D_BW(14), .IDX_W(10), .NUM_W(7)) ifa ();
    spec_frame_tx_if #(.D_BW(14), .IDX_W(2),  .NUM_W(1)) ifb ();
    spec_frame_tx_if #(.D_BW(14), .IDX_W(2),  .NUM_W(2)) ifc ();

    spec_frame_tx #(.D_BW(14), .N_BINS(513), .N_FRAMES(89), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa), .busy(busy_a), .done(done_a));
    spec_frame_tx #(.D_BW(14), .N_BINS(4), .N_FRAMES(2), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb), .busy(busy_b), .done(done_b));
    spec_frame_tx #(.D_BW(14), .N_BINS(3), .N_FRAMES(3), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bus(ifc), .busy(busy_c), .done(done_c));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_c(input bit disturb, output int beats, output int first_cyc,
                         output int last_cyc, output int done_cyc, output int done_cnt,
                         output logic [17:0] nseq, output logic [17:0] iseq);
        beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        nseq = '0; iseq = '0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = '0;
        start_c     = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_c     = disturb && (c == 3 || c == 10);
            ifc.s_data  = 14'(c);
            if (ifc.do_en) begin
                if (beats == 0) first_cyc = c;
                last_cyc = c;
                beats++;
                nseq = {nseq[15:0], ifc.group_num};
                iseq = {iseq[15:0], ifc.group_idx};
            end
            if (done_c) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        start_c = 1'b0;
    endtask

    int vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int bidx[7] = '{0, 0, 0, 1, 2, 2, 3};
    int bdat[7] = '{200, 200, 200, 203, 204, 204, 206};

    initial begin
        int cyc, beats, sent, tag_err, done_cyc, done_cnt, prev_cyc, last_beat_cyc;
        int b512_cyc, b512_last, b512_num, b513_cyc, b513_idx, b513_num, b513_first;
        int exp_idx, exp_num, rest_beats, rest_err, first_cyc, last_cyc, found, bad;
        logic rdy;
        logic [17:0] nseq, iseq;

        ifa.s_valid = 1'b0; ifa.s_data = '0;
        ifb.s_valid = 1'b0; ifb.s_data = '0;
        ifc.s_valid = 1'b0; ifc.s_data = '0;

        // Reset held with start and s_valid high.
        rst = 1'b0; start_a = 1'b1; ifa.s_valid = 1'b1; ifa.s_data = 14'd5;
        repeat (3) @(negedge clk);
        check("rst_do_en",     int'(ifa.do_en), 0);
        check("rst_data",      int'($unsigned(ifa.data_o)), 0);
        check("rst_idx",       int'(ifa.group_idx), 0);
        check("rst_num",       int'(ifa.group_num), 0);
        check("rst_first",     int'(ifa.is_first), 0);
        check("rst_last",      int'(ifa.is_last), 0);
        check("rst_ready",     int'(ifa.s_ready), 0);
        check("rst_busy",      int'(busy_a), 0);
        check("rst_done",      int'(done_a), 0);
        start_a = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy",  int'(busy_a), 0);
        check("idle_ready", int'(ifa.s_ready), 0);
        check("idle_do_en", int'(ifa.do_en), 0);

        // Full run 513 x 89, GAP=2, s_data = bin counter.
        sent = 0; beats = 0; tag_err = 0; done_cnt = 0; done_cyc = -1; prev_cyc = 0;
        last_beat_cyc = -1; b512_cyc = -1; b513_cyc = -1;
        b512_last = 0; b512_num = -1; b513_idx = -1; b513_num = -1; b513_first = 0;
        ifa.s_valid = 1'b1; ifa.s_data = '0; start_a = 1'b1; cyc = 0;
        rdy = ifa.s_ready;
        while (cyc < 46000) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (rdy) sent++;
            ifa.s_data = 14'(sent % 513);
            rdy = ifa.s_ready;
            if (ifa.do_en) begin
                exp_idx = beats % 513;
                exp_num = beats / 513;
                if (int'(ifa.group_idx) != exp_idx || int'(ifa.group_num) != exp_num ||
                    int'($unsigned(ifa.data_o)) != exp_idx ||
                    int'(ifa.is_first) != int'(exp_idx == 0) ||
                    int'(ifa.is_last) != int'(exp_idx == 512))
                    tag_err++;
                if (beats > 0 && (cyc - prev_cyc) != ((exp_idx == 0) ? 3 : 1))
                    tag_err++;
                if (beats == 512) begin
                    b512_cyc = cyc; b512_last = int'(ifa.is_last); b512_num = int'(ifa.group_num);
                end
                if (beats == 513) begin
                    b513_cyc = cyc; b513_idx = int'(ifa.group_idx);
                    b513_num = int'(ifa.group_num); b513_first = int'(ifa.is_first);
                end
                prev_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
            end else if (ifa.is_first || ifa.is_last) begin
                tag_err++;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc > done_cyc + 3) break;
        end
        ifa.s_valid = 1'b0;
        check("full_beats",     beats, 45657);
        check("full_tags",      tag_err, 0);
        check("b512_cyc",       b512_cyc, 514);
        check("b512_last",      b512_last, 1);
        check("b512_num",       b512_num, 0);
        check("b513_cyc",       b513_cyc, 517);
        check("b513_idx",       b513_idx, 0);
        check("b513_num",       b513_num, 1);
        check("b513_first",     b513_first, 1);
        check("full_last_beat", last_beat_cyc, 45834);
        check("full_done_cyc",  done_cyc, 45835);
        check("full_done_cnt",  done_cnt, 1);
        check("full_busy_end",  int'(busy_a), 0);

        // Bubbles on the 4 x 2 instance.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ifb.s_valid = (vpat[i] != 0);
            ifb.s_data  = 14'(200 + i);
            @(negedge clk);
            check($sformatf("bub_en%0d", i),    int'(ifb.do_en), vpat[i]);
            check($sformatf("bub_idx%0d", i),   int'(ifb.group_idx), bidx[i]);
            check($sformatf("bub_data%0d", i),  int'($unsigned(ifb.data_o)), bdat[i]);
            check($sformatf("bub_first%0d", i), int'(ifb.is_first), int'(vpat[i] != 0 && bidx[i] == 0));
            check($sformatf("bub_last%0d", i),  int'(ifb.is_last), int'(vpat[i] != 0 && bidx[i] == 3));
        end
        ifb.s_valid = 1'b1;
        rest_beats = 0; rest_err = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifb.do_en) begin
                if (int'(ifb.group_num) != 1 || int'(ifb.group_idx) != rest_beats) rest_err++;
                rest_beats++;
            end
            if (done_b) done_cnt++;
        end
        ifb.s_valid = 1'b0;
        check("bub_rest_beats", rest_beats, 4);
        check("bub_rest_tags",  rest_err, 0);
        check("bub_done_cnt",   done_cnt, 1);

        // GAP=0, 3 x 3: undisturbed then with start pulses in STREAM and DONE.
        for (int d = 0; d < 2; d++) begin
            run_c(d[0], beats, first_cyc, last_cyc, done_cyc, done_cnt, nseq, iseq);
            check($sformatf("g0_beats_d%0d", d),    beats, 9);
            check($sformatf("g0_first_d%0d", d),    first_cyc, 2);
            check($sformatf("g0_last_d%0d", d),     last_cyc, 10);
            check($sformatf("g0_done_cyc_d%0d", d), done_cyc, 11);
            check($sformatf("g0_done_cnt_d%0d", d), done_cnt, 1);
            check($sformatf("g0_nums_d%0d", d),     int'(nseq), int'(18'b000000010101101010));
            check($sformatf("g0_idxs_d%0d", d),     int'(iseq), int'(18'b000110000110000110));
            check($sformatf("g0_busy_d%0d", d),     int'(busy_c), 0);
        end
        ifc.s_valid = 1'b0;

        // Mid-run reset at frame 1, bin 100.
        found = 0;
        ifa.s_valid = 1'b1; ifa.s_data = '0; start_a = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (ifa.do_en && int'(ifa.group_num) == 1 && int'(ifa.group_idx) == 100) begin
                found = 1;
                break;
            end
        end
        check("mid_found", found, 1);
        rst = 1'b0;
        #1;
        check("mid_do_en", int'(ifa.do_en), 0);
        check("mid_data",  int'($unsigned(ifa.data_o)), 0);
        check("mid_idx",   int'(ifa.group_idx), 0);
        check("mid_num",   int'(ifa.group_num), 0);
        check("mid_ready", int'(ifa.s_ready), 0);
        check("mid_busy",  int'(busy_a), 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_a || busy_a || ifa.do_en) bad++;
        end
        check("mid_quiet", bad, 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        check("restart_en",    int'(ifa.do_en), 1);
        check("restart_idx",   int'(ifa.group_idx), 0);
        check("restart_num",   int'(ifa.group_num), 0);
        check("restart_first", int'(ifa.is_first), 1);
        ifa.s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
